// File: rtl/alu_op_decoder.sv
// ---------------------------------------------------------------------------
// alu_op_decoder
//   Decode stage between fetch and the ALU. It turns an RV32I instruction word
//   into the 3-bit ALU operation select plus operand routing: register
//   addresses, immediate and the use_imm mux control. It is a one-entry
//   registered pipeline stage with a valid/ready handshake, a synchronous
//   flush and a saturating count of accepted illegal instructions.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready     fetch-side handshake (in_ready is combinational)
//   instr[31:0]            RV32I instruction word
//   flush                  kills the held bundle and the incoming instruction
//   out_valid, out_ready   ALU-side handshake
//   sel[2:0]               0 ADD, 1 AND, 2 XOR, 3 SLL, 4 SRA, 5 SUB, 6 JALR, 7 zero
//   rs1_addr, rs2_addr,
//   rd_addr[4:0]           register addresses (0 when unused)
//   imm[31:0]              immediate (0 when unused)
//   use_imm                ALU operand B takes imm instead of rs2
//   reg_write              instruction writes rd (x0 included)
//   illegal                bundle is an undecodable instruction
//   illegal_cnt[CNT_W-1:0] saturating count of accepted illegal instructions
// ---------------------------------------------------------------------------
module alu_op_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       sel,
   output logic [4:0]       rs1_addr,
   output logic [4:0]       rs2_addr,
   output logic [4:0]       rd_addr,
   output logic [31:0]      imm,
   output logic             use_imm,
   output logic             reg_write,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef enum logic [2:0] {
      SEL_ADD  = 3'd0,
      SEL_AND  = 3'd1,
      SEL_XOR  = 3'd2,
      SEL_SLL  = 3'd3,
      SEL_SRA  = 3'd4,
      SEL_SUB  = 3'd5,
      SEL_JALR = 3'd6,
      SEL_ZERO = 3'd7
   } sel_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];

   // Decoded (next) bundle
   sel_t        d_sel;
   logic [4:0]  d_rs1, d_rs2, d_rd;
   logic [31:0] d_imm;
   logic        d_use_imm, d_reg_write, d_legal;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      d_sel       = SEL_ADD;
      d_rs1       = instr[19:15];
      d_rs2       = 5'd0;
      d_rd        = instr[11:7];
      d_imm       = {{20{instr[31]}}, instr[31:20]};
      d_use_imm   = 1'b1;
      d_reg_write = 1'b1;
      d_legal     = 1'b0;

      unique case (opcode)
         OPC_OP: begin
            d_rs2     = instr[24:20];
            d_imm     = 32'd0;
            d_use_imm = 1'b0;
            d_legal   = 1'b1;
            if      (f3 == 3'b000 && f7 == F7_ZERO) d_sel = SEL_ADD;
            else if (f3 == 3'b000 && f7 == F7_ALT)  d_sel = SEL_SUB;
            else if (f3 == 3'b111 && f7 == F7_ZERO) d_sel = SEL_AND;
            else if (f3 == 3'b100 && f7 == F7_ZERO) d_sel = SEL_XOR;
            else if (f3 == 3'b001 && f7 == F7_ZERO) d_sel = SEL_SLL;
            else if (f3 == 3'b101 && f7 == F7_ALT)  d_sel = SEL_SRA;
            else                                    d_legal = 1'b0;
         end
         OPC_OP_IMM: begin
            d_legal = 1'b1;
            if      (f3 == 3'b000) d_sel = SEL_ADD;
            else if (f3 == 3'b111) d_sel = SEL_AND;
            else if (f3 == 3'b100) d_sel = SEL_XOR;
            else if (f3 == 3'b001 && f7 == F7_ZERO) d_sel = SEL_SLL;
            else if (f3 == 3'b101 && f7 == F7_ALT)  d_sel = SEL_SRA;
            else                                    d_legal = 1'b0;
            // Shift-immediates carry only the 5-bit shamt; f7 is an opcode field.
            if (f3 == 3'b001 || f3 == 3'b101) d_imm = {27'd0, instr[24:20]};
         end
         OPC_LOAD: begin
            d_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                      (f3 == 3'b100) || (f3 == 3'b101);
         end
         OPC_STORE: begin
            d_rs2       = instr[24:20];
            d_rd        = 5'd0;
            d_reg_write = 1'b0;
            d_imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            d_legal     = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
         end
         OPC_JALR: begin
            d_sel   = SEL_JALR;
            d_legal = (f3 == 3'b000);
         end
         OPC_LUI: begin
            d_rs1   = 5'd0;
            d_imm   = {instr[31:12], 12'h000};
            d_legal = 1'b1;
         end
         default: d_legal = 1'b0;
      endcase

      // Undecodable words collapse to a clean all-zero bundle with sel 7.
      if (!d_legal) begin
         d_sel       = SEL_ZERO;
         d_rs1       = 5'd0;
         d_rs2       = 5'd0;
         d_rd        = 5'd0;
         d_imm       = 32'd0;
         d_use_imm   = 1'b0;
         d_reg_write = 1'b0;
      end
   end

   assign in_ready = !out_valid || out_ready;

   logic load;
   assign load = in_valid && in_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         out_valid   <= 1'b0;
         sel         <= 3'd0;
         rs1_addr    <= 5'd0;
         rs2_addr    <= 5'd0;
         rd_addr     <= 5'd0;
         imm         <= 32'd0;
         use_imm     <= 1'b0;
         reg_write   <= 1'b0;
         illegal     <= 1'b0;
         illegal_cnt <= '0;
      end else if (flush) begin
         // Bundle fields keep their last values; only validity is dropped.
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         sel       <= d_sel;
         rs1_addr  <= d_rs1;
         rs2_addr  <= d_rs2;
         rd_addr   <= d_rd;
         imm       <= d_imm;
         use_imm   <= d_use_imm;
         reg_write <= d_reg_write;
         illegal   <= !d_legal;
         if (!d_legal && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Decode stage that turns 32-bit RV32I instructions into the 3-bit ALU operation select plus operand routing: register addresses, immediate, and the use_imm mux control.
- Sits between fetch and the ALU. It is the producing end of the ALU's sel interface.
- One-entry registered pipeline stage with a valid/ready handshake, a synchronous flush, and a saturating illegal-instruction counter.

Parameters:
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction valid from fetch
- in_ready  out  1  stage can accept an instruction
- instr  in  32  RV32I instruction word
- flush  in  1  synchronous kill of the held instruction and the incoming one
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  consumer accepts bundle
- sel  out  3  ALU op: 0 ADD, 1 AND, 2 XOR, 3 SLL, 4 SRA, 5 SUB, 6 JALR target, 7 zero
- rs1_addr  out  5  source register 1
- rs2_addr  out  5  source register 2 (0 when unused)
- rd_addr  out  5  destination register (0 when no writeback)
- imm  out  32  sign-extended immediate (0 when unused)
- use_imm  out  1  ALU operand B = imm instead of rs2
- reg_write  out  1  instruction writes rd
- illegal  out  1  bundle is an undecodable instruction
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (async, rst_n=0): out_valid=0, illegal_cnt=0, and all bundle outputs=0 (sel=0, addrs=0, imm=0, flags=0).
- Handshake:
  - in_ready = !out_valid || out_ready, a combinational pass-through of out_ready.
  - Transfer-in when in_valid && in_ready. The decoded bundle is registered and appears with out_valid=1 on the next edge (latency 1).
  - Transfer-out when out_valid && out_ready.
  - Simultaneous in/out transfer gives back-to-back throughput of 1 per cycle.
  - Bundle outputs hold stable while out_valid && !out_ready.
  - If out_valid is cleared without a new load, the bundle fields retain their last values.
- Flush: on the next edge out_valid=0. Any instruction presented that cycle is discarded even if in_valid && in_ready. illegal_cnt is not incremented for a flushed instruction. Flush has priority over load.
- Decode (opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]):
  - OP 0110011, use_imm=0, reg_write=1:
    - f3=000, f7=0000000: ADD, sel 0
    - f3=000, f7=0100000: SUB, sel 5
    - f3=111, f7=0: AND, sel 1
    - f3=100, f7=0: XOR, sel 2
    - f3=001, f7=0: SLL, sel 3
    - f3=101, f7=0100000: SRA, sel 4
  - OP-IMM 0010011, use_imm=1, reg_write=1, rs2=0, I-immediate:
    - ADDI f3=000: sel 0
    - ANDI f3=111: sel 1
    - XORI f3=100: sel 2
    - SLLI f3=001 with f7=0: sel 3
    - SRAI f3=101 with f7=0100000: sel 4
    - For SLLI/SRAI, imm = zero-extended instr[24:20].
  - LOAD 0000011, f3 in {000,001,010,100,101}: sel 0, I-immediate, use_imm=1, reg_write=1, rs2=0.
  - STORE 0100011, f3 in {000,001,010}: sel 0, S-immediate {instr[31:25],instr[11:7]} sign-extended, use_imm=1, reg_write=0, rd=0.
  - JALR 1100111, f3=000: sel 6, I-immediate, use_imm=1, reg_write=1, rs2=0.
  - LUI 0110111: sel 0, rs1=0, rs2=0, imm = {instr[31:12],12'h000}, use_imm=1, reg_write=1.
  - Anything else: illegal=1, sel 7, reg_write=0, use_imm=0, imm=0, all addrs=0.
- Writes with rd=x0 keep reg_write=1; x0 suppression happens downstream.
- illegal_cnt:
  - +1 on each accepted (non-flushed) illegal instruction.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by reset.
- Reset mid-transfer: the held bundle is dropped, and out_valid=0 immediately (asynchronously).

Test Plan:
- Reset, then 0x002081B3 (add x3,x1,x2) with out_ready=1 -> one cycle later out_valid=1, sel=0, rs1=1, rs2=2, rd=3, use_imm=0, reg_write=1; in_ready stays 1.
- Back-to-back 0x402081B3 (sub x3,x1,x2) then 0x40335293 (srai x5,x6,3) -> sel=5 on the first bundle; on the second, sel=4, rs1=6, rd=5, imm=3, use_imm=1; no bubble between them.
- 0xFFF00093 (addi x1,x0,-1) with out_ready=0 for 3 cycles -> bundle held with imm=0xFFFFFFFF, rs1=0, rd=1; in_ready=0 throughout; a second instruction is accepted only on the cycle out_ready=1.
- 0x0020A423 (sw x2,8(x1)) -> sel=0, rs1=1, rs2=2, imm=8, reg_write=0, rd=0. 0x000280E7 (jalr x1,0(x5)) -> sel=6, rs1=5, rd=1. 0x123453B7 (lui x7,0x12345) -> imm=0x12345000, rs1=0, rd=7.
- 0x00000000 accepted 300 times -> each bundle has illegal=1, sel=7; illegal_cnt saturates at 255. Then assert rst_n=0 -> illegal_cnt=0 and out_valid=0 without a clock edge.
- Flush asserted in the same cycle as in_valid with a held bundle -> next cycle out_valid=0, and illegal_cnt is unchanged even if the incoming word was illegal.
